// File: rtl/rr_merge_sequencer32.sv
// Round-robin sequencer sharing one drive/free channel among 32 requesters.
// One owner at a time: IDLE picks, ISSUE pulses drive, WAIT holds grant until free or watchdog, DONE acks.
module rr_merge_sequencer32 #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_req,
    input  logic        i_freeNext,
    output logic        o_driveNext,
    output logic [31:0] o_grant,
    output logic [4:0]  o_grantIdx,
    output logic [31:0] o_ack,
    output logic        o_timeout,
    output logic        o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    // Watchdog compare value; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] LIM = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_next;
    logic [4:0]       r_ptr;
    logic [4:0]       r_idx;
    logic [31:0]      r_grant;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;

    logic             w_hit;
    logic [4:0]       w_sel;
    logic [4:0]       w_cand;
    logic             w_to;

    // Scanning downward leaves the lowest rotated offset from r_ptr as the winner.
    always_comb begin
        w_hit  = |i_req;
        w_sel  = r_ptr;
        w_cand = '0;
        for (int i = 31; i >= 0; i--) begin
            w_cand = r_ptr + 5'(i);
            if (i_req[w_cand]) w_sel = w_cand;
        end
    end

    assign w_to = (TIMEOUT != 0) && (r_cnt == LIM);

    always_comb begin
        w_next      = r_state;
        o_driveNext = 1'b0;
        o_ack       = '0;
        o_timeout   = 1'b0;
        o_busy      = 1'b1;
        o_grant     = r_grant;
        o_grantIdx  = r_idx;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_hit) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                o_driveNext = 1'b1;
                w_next      = i_freeNext ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (i_freeNext || w_to) w_next = S_DONE;
            end
            S_DONE: begin
                o_ack     = r_grant;
                o_timeout = r_flag;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_grant <= 32'd1 << w_sel;
                        r_idx   <= w_sel;
                        r_flag  <= 1'b0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A free in the same cycle as expiry wins, so no abort flag.
                    if (!i_freeNext && w_to) r_flag <= 1'b1;
                end
                S_DONE: begin
                    r_ptr   <= r_idx + 5'd1;
                    r_grant <= '0;
                    r_idx   <= '0;
                    r_flag  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_merge_sequencer32.sv
// Scoreboard bench: main process drives requests/free and queues expectations, negedge monitor checks.
module tb_rr_merge_sequencer32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_req;
    logic        i_freeNext;
    logic        o_driveNext;
    logic [31:0] o_grant;
    logic [4:0]  o_grantIdx;
    logic [31:0] o_ack;
    logic        o_timeout;
    logic        o_busy;

    rr_merge_sequencer32 #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_freeNext(i_freeNext),
        .o_driveNext(o_driveNext), .o_grant(o_grant), .o_grantIdx(o_grantIdx),
        .o_ack(o_ack), .o_timeout(o_timeout), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; bit to; int lat;} ack_t;
    typedef struct {int cyc; logic [31:0] grant; logic [4:0] idx; logic [31:0] ack;
                    logic drive; logic to; logic busy;} snap_t;

    ack_t  ackq[$];
    int    grantq[$];
    snap_t snapq[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, drv_cyc = 0;
    int free_dly = -1, fcnt = -1;
    int rearm_left[32], rearm_cnt[32];
    int to_bad = 0;
    bit done = 0, fin = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_snap(input int c, input logic [31:0] g, input logic [4:0] ix,
                               input logic [31:0] a, input logic d, input logic t, input logic b);
        snap_t s;
        s.cyc = c; s.grant = g; s.idx = ix; s.ack = a; s.drive = d; s.to = t; s.busy = b;
        snapq.push_back(s);
    endtask

    task automatic push_txn(input int idx, input bit to, input int lat);
        ack_t a;
        a.idx = idx; a.to = to; a.lat = lat;
        grantq.push_back(idx);
        ackq.push_back(a);
    endtask

    // One cycle step: requesters drop on ack (optionally re-raise 2 cycles later),
    // downstream answers free_dly cycles after drive (-1 = never).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        i_freeNext = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (rearm_cnt[k] > 0) begin
                rearm_cnt[k]--;
                if (rearm_cnt[k] == 0) i_req[k] = 1'b1;
            end
        end
        if (o_ack != 0) begin
            for (int k = 0; k < 32; k++) begin
                if (o_ack[k]) begin
                    i_req[k] = 1'b0;
                    if (rearm_left[k] > 0) begin
                        rearm_left[k]--;
                        rearm_cnt[k] = 2;
                    end
                end
            end
        end
        if (o_driveNext) fcnt = free_dly;
        if (fcnt == 0) begin
            i_freeNext = 1'b1;
            fcnt = -1;
        end else if (fcnt > 0) begin
            fcnt--;
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((ackq.size() != 0 || o_busy || i_req != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) to_bad++;
        tick();
    endtask

    always @(negedge clk) begin
        if (snapq.size() != 0 && snapq[0].cyc <= cyc) begin
            snap_t s;
            s = snapq.pop_front();
            chk("snap_grant", o_grant, s.grant);
            chk("snap_idx", 32'(o_grantIdx), 32'(s.idx));
            chk("snap_ack", o_ack, s.ack);
            chk("snap_drive", 32'(o_driveNext), 32'(s.drive));
            chk("snap_timeout", 32'(o_timeout), 32'(s.to));
            chk("snap_busy", 32'(o_busy), 32'(s.busy));
        end
        if (!rst) begin
            chk("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
            chk("ack_with_drive", 32'(o_driveNext && (o_ack != 0)), 32'd0);
            chk("timeout_no_ack", 32'(o_timeout && (o_ack == 0)), 32'd0);
            if (o_driveNext) begin
                drv_cyc = cyc;
                if (grantq.size() == 0) chk("unexpected_drive", 32'(o_grantIdx), 32'hFFFFFFFF);
                else begin
                    int g;
                    g = grantq.pop_front();
                    chk("drive_grant", o_grant, 32'd1 << g);
                    chk("drive_idx", 32'(o_grantIdx), 32'(g));
                end
            end
            if (o_ack != 0) begin
                if (ackq.size() == 0) chk("unexpected_ack", o_ack, 32'd0);
                else begin
                    ack_t a;
                    a = ackq.pop_front();
                    chk("ack_vec", o_ack, 32'd1 << a.idx);
                    chk("ack_timeout", 32'(o_timeout), 32'(a.to));
                    chk("ack_latency", 32'(cyc - drv_cyc), 32'(a.lat));
                end
            end
        end
        if (done && !fin) begin
            chk("ackq_drained", 32'(ackq.size()), 32'd0);
            chk("grantq_drained", 32'(grantq.size()), 32'd0);
            chk("snapq_drained", 32'(snapq.size()), 32'd0);
            chk("wait_budget", 32'(to_bad), 32'd0);
            fin = 1;
        end
    end

    initial begin
        int r;
        rst = 1'b1; i_req = '0; i_freeNext = 1'b0;
        for (int k = 0; k < 32; k++) begin rearm_left[k] = 0; rearm_cnt[k] = 0; end
        tick();
        expect_snap(cyc, '0, '0, '0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // Single request idx 4, free 3 cycles after drive
        free_dly = 3;
        push_txn(4, 0, 4);
        i_req = 32'h0000_0010; r = cyc;
        expect_snap(r + 1, 32'h10, 5'd4, '0, 1, 0, 1);
        expect_snap(r + 5, 32'h10, 5'd4, 32'h10, 0, 0, 1);
        expect_snap(r + 6, '0, '0, '0, 0, 0, 0);
        wait_quiet(50);

        // Round-robin from ptr=5: 31, 0, 4
        free_dly = 1;
        push_txn(31, 0, 2); push_txn(0, 0, 2); push_txn(4, 0, 2);
        i_req = 32'h8000_0011;
        wait_quiet(60);
        expect_snap(cyc, '0, '0, '0, 0, 0, 0);
        tick();

        // All 32 after reset (ptr=0), each re-raised once: 0..31, 0..31
        rst = 1'b1;
        tick();
        rst = 1'b0;
        free_dly = 0;
        for (int k = 0; k < 32; k++) rearm_left[k] = 1;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 32; k++) push_txn(k, 0, 1);
        i_req = 32'hFFFF_FFFF;
        wait_quiet(600);

        // Watchdog abort: no free, ack+timeout 9 cycles after drive
        free_dly = -1;
        push_txn(2, 1, 9);
        i_req = 32'h0000_0004; r = cyc;
        expect_snap(r + 10, 32'h4, 5'd2, 32'h4, 0, 1, 1);
        wait_quiet(40);

        // Free on the 8th WAIT cycle beats the watchdog
        free_dly = 8;
        push_txn(3, 0, 9);
        i_req = 32'h0000_0008;
        wait_quiet(40);

        // Free in ISSUE: 3-cycle transaction
        free_dly = 0;
        push_txn(7, 0, 1);
        i_req = 32'h0000_0080; r = cyc;
        expect_snap(r + 1, 32'h80, 5'd7, '0, 1, 0, 1);
        expect_snap(r + 2, 32'h80, 5'd7, 32'h80, 0, 0, 1);
        expect_snap(r + 3, '0, '0, '0, 0, 0, 0);
        wait_quiet(40);

        // Spurious free while idle
        free_dly = -1;
        i_freeNext = 1'b1;
        expect_snap(cyc + 1, '0, '0, '0, 0, 0, 0);
        expect_snap(cyc + 2, '0, '0, '0, 0, 0, 0);
        tick(); tick(); tick();

        // Reset in WAIT with grant idx 8; ptr must return to 0
        push_txn(8, 0, 0);
        void'(ackq.pop_back());
        i_req = 32'h0000_0100;
        tick(); tick();
        expect_snap(cyc, 32'h100, 5'd8, '0, 0, 0, 1);
        tick();
        rst = 1'b1; i_req = '0;
        expect_snap(cyc, '0, '0, '0, 0, 0, 0);
        tick();
        rst = 1'b0;
        free_dly = 1;
        push_txn(0, 0, 2); push_txn(8, 0, 2);
        i_req = 32'h0000_0101;
        wait_quiet(60);

        done = 1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
